// File: rtl/llsc_link_monitor.sv
// Load-linked / store-conditional reservation monitor for the EX/MEM D-cache path.
// Holds one reservation, grants SC writes combinationally, registers the SC result.
module llsc_link_monitor #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned GRANULE_BITS = 2,
  parameter int unsigned LINK_TIMEOUT = 1024,
  parameter int unsigned CNT_WIDTH    = 11
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_valid,
  input  logic                  i_is_sw,
  input  logic                  i_lladdr_wr,
  input  logic                  i_is_sc,
  input  logic [DATA_WIDTH-1:0] i_wr_reg_val,
  input  logic                  i_invalidate,
  output logic                  o_sc_pass,
  output logic                  o_sc_done,
  output logic [DATA_WIDTH-1:0] o_sc_rd_value,
  output logic                  o_link_valid,
  output logic [DATA_WIDTH-1:0] o_link_addr
);

  typedef enum logic [0:0] {StUnlinked, StLinked} state_e;

  localparam logic [DATA_WIDTH-1:0] GranMask =
      ~DATA_WIDTH'((64'd1 << GRANULE_BITS) - 64'd1);
  localparam bit                    TimeoutEn = (LINK_TIMEOUT != 0);
  localparam logic [CNT_WIDTH-1:0]  CntLast   = CNT_WIDTH'(TimeoutEn ? LINK_TIMEOUT - 1 : 0);
  localparam logic [CNT_WIDTH-1:0]  CntMax    = '1;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] link_addr_q, link_addr_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  sc_done_q, sc_done_d;
  logic                  sc_res_q, sc_res_d;

  logic linked, match, sc_req, ll_req, sw_req, sc_pass;

  assign linked  = (state_q == StLinked);
  // link_addr_q is stored already masked, so only the request needs masking.
  assign match   = ((i_wr_reg_val & GranMask) == link_addr_q);
  assign sc_req  = i_valid & i_is_sc;
  assign ll_req  = i_valid & i_lladdr_wr;
  assign sw_req  = i_valid & i_is_sw;
  assign sc_pass = sc_req & linked & match & ~i_invalidate & ~rst;

  always_comb begin
    state_d     = state_q;
    link_addr_d = link_addr_q;
    cnt_d       = cnt_q;
    sc_done_d   = 1'b0;
    sc_res_d    = sc_res_q;
    if (i_invalidate) begin
      state_d = StUnlinked;
      cnt_d   = '0;
      if (sc_req) begin
        sc_done_d = 1'b1;
        sc_res_d  = 1'b0;
      end
    end else if (sc_req) begin
      state_d   = StUnlinked;
      cnt_d     = '0;
      sc_done_d = 1'b1;
      sc_res_d  = sc_pass;
    end else if (ll_req) begin
      state_d     = StLinked;
      link_addr_d = i_wr_reg_val & GranMask;
      cnt_d       = '0;
    end else if (sw_req) begin
      // A non-matching store neither breaks the link nor ages it.
      if (linked && match) begin
        state_d = StUnlinked;
        cnt_d   = '0;
      end
    end else if (linked) begin
      if (TimeoutEn && (cnt_q == CntLast)) begin
        state_d = StUnlinked;
        cnt_d   = '0;
      end else if (cnt_q != CntMax) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StUnlinked;
      link_addr_q <= '0;
      cnt_q       <= '0;
      sc_done_q   <= 1'b0;
      sc_res_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      link_addr_q <= link_addr_d;
      cnt_q       <= cnt_d;
      sc_done_q   <= sc_done_d;
      sc_res_q    <= sc_res_d;
    end
  end

  assign o_sc_pass     = sc_pass;
  assign o_sc_done     = sc_done_q;
  assign o_sc_rd_value = {{(DATA_WIDTH-1){1'b0}}, sc_res_q};
  assign o_link_valid  = linked;
  assign o_link_addr   = link_addr_q;

endmodule

// File: tb/tb_llsc_link_monitor.sv
// Directed vector bench for llsc_link_monitor with a short timeout (LINK_TIMEOUT = 4).
module tb_llsc_link_monitor;

  typedef struct {
    logic        rst, v, sw, ll, sc, inv;
    logic [31:0] addr;
    logic        pass, done;
    logic [31:0] rdv;
    logic        lv;
    logic [31:0] la;
  } vec_t;

  logic        clk;
  logic        rst, i_valid, i_is_sw, i_lladdr_wr, i_is_sc, i_invalidate;
  logic [31:0] i_wr_reg_val;
  logic        o_sc_pass, o_sc_done, o_link_valid;
  logic [31:0] o_sc_rd_value, o_link_addr;

  int n_vec  = 0;
  int n_fail = 0;
  vec_t vecs[$];

  llsc_link_monitor #(
    .DATA_WIDTH  (32),
    .GRANULE_BITS(2),
    .LINK_TIMEOUT(4),
    .CNT_WIDTH   (11)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .i_valid      (i_valid),
    .i_is_sw      (i_is_sw),
    .i_lladdr_wr  (i_lladdr_wr),
    .i_is_sc      (i_is_sc),
    .i_wr_reg_val (i_wr_reg_val),
    .i_invalidate (i_invalidate),
    .o_sc_pass    (o_sc_pass),
    .o_sc_done    (o_sc_done),
    .o_sc_rd_value(o_sc_rd_value),
    .o_link_valid (o_link_valid),
    .o_link_addr  (o_link_addr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic vec_t mk(input logic r, v, sw, ll, sc, inv, input logic [31:0] addr,
                              input logic pass, done, input logic [31:0] rdv,
                              input logic lv, input logic [31:0] la);
    vec_t t;
    t.rst = r; t.v = v; t.sw = sw; t.ll = ll; t.sc = sc; t.inv = inv; t.addr = addr;
    t.pass = pass; t.done = done; t.rdv = rdv; t.lv = lv; t.la = la;
    return t;
  endfunction

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got 0x%08h, expected 0x%08h", name, idx, act, exp);
    end
  endtask

  // Drive one cycle of inputs, check the combinational grant, then the registered outputs.
  task automatic apply(input vec_t t, input int idx);
    rst          = t.rst;
    i_valid      = t.v;
    i_is_sw      = t.sw;
    i_lladdr_wr  = t.ll;
    i_is_sc      = t.sc;
    i_invalidate = t.inv;
    i_wr_reg_val = t.addr;
    #1;
    check("sc_pass", idx, {31'b0, o_sc_pass}, {31'b0, t.pass});
    @(posedge clk);
    #1;
    check("sc_done", idx, {31'b0, o_sc_done}, {31'b0, t.done});
    check("sc_rd_value", idx, o_sc_rd_value, t.rdv);
    check("link_valid", idx, {31'b0, o_link_valid}, {31'b0, t.lv});
    check("link_addr", idx, o_link_addr, t.la);
  endtask

  initial begin
    //                 rst v sw ll sc inv addr           pass done rdv lv la
    // reset with a live SC
    vecs.push_back(mk(1, 1, 0, 0, 1, 0, 32'h0000_1004, 0, 0, 0, 0, 32'h0));
    vecs.push_back(mk(1, 1, 0, 0, 1, 0, 32'h0000_1004, 0, 0, 0, 0, 32'h0));
    // basic LL/SC pair
    vecs.push_back(mk(0, 1, 0, 1, 0, 0, 32'h0000_1004, 0, 0, 0, 1, 32'h1004));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,         0, 0, 0, 1, 32'h1004));
    vecs.push_back(mk(0, 1, 0, 0, 1, 0, 32'h0000_1006, 1, 1, 1, 0, 32'h1004));
    vecs.push_back(mk(0, 1, 0, 0, 1, 0, 32'h0000_1004, 0, 1, 0, 0, 32'h1004));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,         0, 0, 0, 0, 32'h1004));
    // store kill
    vecs.push_back(mk(0, 1, 0, 1, 0, 0, 32'h0000_2000, 0, 0, 0, 1, 32'h2000));
    vecs.push_back(mk(0, 1, 1, 0, 0, 0, 32'h0000_2008, 0, 0, 0, 1, 32'h2000));
    vecs.push_back(mk(0, 1, 1, 0, 0, 0, 32'h0000_2000, 0, 0, 0, 0, 32'h2000));
    vecs.push_back(mk(0, 1, 0, 0, 1, 0, 32'h0000_2000, 0, 1, 0, 0, 32'h2000));
    // timeout: 3 idle cycles survive
    vecs.push_back(mk(0, 1, 0, 1, 0, 0, 32'h0000_3000, 0, 0, 0, 1, 32'h3000));
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 0, 1, 32'h3000));
    vecs.push_back(mk(0, 1, 0, 0, 1, 0, 32'h0000_3000, 1, 1, 1, 0, 32'h3000));
    // timeout: the 4th idle cycle drops the link
    vecs.push_back(mk(0, 1, 0, 1, 0, 0, 32'h0000_3000, 0, 0, 1, 1, 32'h3000));
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 1, 1, 32'h3000));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,         0, 0, 1, 0, 32'h3000));
    vecs.push_back(mk(0, 1, 0, 0, 1, 0, 32'h0000_3000, 0, 1, 0, 0, 32'h3000));
    // invalidate collisions
    vecs.push_back(mk(0, 1, 0, 1, 0, 0, 32'h0000_4000, 0, 0, 0, 1, 32'h4000));
    vecs.push_back(mk(0, 1, 0, 0, 1, 1, 32'h0000_4000, 0, 1, 0, 0, 32'h4000));
    vecs.push_back(mk(0, 1, 0, 1, 0, 1, 32'h0000_5000, 0, 0, 0, 0, 32'h4000));
    // re-arm and priority
    vecs.push_back(mk(0, 1, 0, 1, 0, 0, 32'h0000_6000, 0, 0, 0, 1, 32'h6000));
    vecs.push_back(mk(0, 1, 0, 1, 0, 0, 32'h0000_7000, 0, 0, 0, 1, 32'h7000));
    vecs.push_back(mk(0, 1, 0, 0, 1, 0, 32'h0000_6000, 0, 1, 0, 0, 32'h7000));
    vecs.push_back(mk(0, 1, 1, 1, 0, 0, 32'h0000_8000, 0, 0, 0, 1, 32'h8000));
    // flags without i_valid are ignored; back-to-back SCs
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 32'h0000_8000, 0, 0, 0, 1, 32'h8000));
    vecs.push_back(mk(0, 1, 0, 0, 1, 0, 32'h0000_8001, 1, 1, 1, 0, 32'h8000));
    vecs.push_back(mk(0, 1, 0, 0, 1, 0, 32'h0000_8000, 0, 1, 0, 0, 32'h8000));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,         0, 0, 0, 0, 32'h8000));
    // reset while linked, with a matching SC present
    vecs.push_back(mk(0, 1, 0, 1, 0, 0, 32'h0000_9000, 0, 0, 0, 1, 32'h9000));
    vecs.push_back(mk(1, 1, 0, 0, 1, 0, 32'h0000_9000, 0, 0, 0, 0, 32'h0));

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

    // Non-matching stores must not age the link: 2 idles + 3 SW misses + 1 idle, SC passes.
    apply(mk(0, 1, 0, 1, 0, 0, 32'h0000_A000, 0, 0, 0, 1, 32'hA000), 100);
    for (int i = 0; i < 2; i++)
      apply(mk(0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 0, 1, 32'hA000), 101 + i);
    for (int i = 0; i < 3; i++)
      apply(mk(0, 1, 1, 0, 0, 0, 32'h0000_A008, 0, 0, 0, 1, 32'hA000), 103 + i);
    apply(mk(0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 0, 1, 32'hA000), 106);
    apply(mk(0, 1, 0, 0, 1, 0, 32'h0000_A003, 1, 1, 1, 0, 32'hA000), 107);

    // LL re-arm restarts the age counter: LL, 3 idles, LL, 3 idles, SC passes.
    apply(mk(0, 1, 0, 1, 0, 0, 32'h0000_B000, 0, 0, 1, 1, 32'hB000), 110);
    for (int i = 0; i < 3; i++)
      apply(mk(0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 1, 1, 32'hB000), 111 + i);
    apply(mk(0, 1, 0, 1, 0, 0, 32'h0000_B004, 0, 0, 1, 1, 32'hB004), 114);
    for (int i = 0; i < 3; i++)
      apply(mk(0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 1, 1, 32'hB004), 115 + i);
    apply(mk(0, 1, 0, 0, 1, 0, 32'h0000_B004, 1, 1, 1, 0, 32'hB004), 118);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
